// File: rtl/load_store_unit.sv
// Load/store unit: bridges RV32I core load/store requests to a req/gnt/rvalid
// memory port, with lane steering, load extension and an access timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        LsuErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  f3_q;
   logic        we_q, err_q;
   logic [7:0]  cnt;

   logic        access, f3_bad, misalign, illegal, tmo;
   logic        accept, take_rd, zero_rd, set_err;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [31:0] rd_ext;

   always_comb begin
      access   = MemRead | MemWrite;
      f3_bad   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (MemWrite && funct3[2]);
      misalign = ((funct3[1:0] == 2'b01) && Addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
      illegal  = (MemRead & MemWrite) | f3_bad | misalign;
      tmo      = (cnt == 8'(TIMEOUT_CYCLES - 1));
   end

   // Completion in the same cycle as the last allowed count wins over the timeout.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      take_rd  = 1'b0;
      zero_rd  = 1'b0;
      set_err  = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (illegal) begin
                  state_nx = DONE;
                  set_err  = 1'b1;
                  zero_rd  = MemRead & ~MemWrite & misalign;
               end else begin
                  state_nx = REQ;
                  accept   = 1'b1;
               end
            end
         end
         REQ: begin
            if (mem_gnt && we_q) begin
               state_nx = DONE;
            end else if (mem_gnt && mem_rvalid) begin
               state_nx = DONE;
               take_rd  = 1'b1;
            end else if (tmo) begin
               state_nx = DONE;
               set_err  = 1'b1;
               zero_rd  = 1'b1;
            end else if (mem_gnt) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            if (mem_rvalid) begin
               state_nx = DONE;
               take_rd  = 1'b1;
            end else if (tmo) begin
               state_nx = DONE;
               set_err  = 1'b1;
               zero_rd  = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         f3_q     <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt      <= '0;
         ReadData <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q  <= Addr;
            f3_q    <= funct3;
            wdata_q <= WriteData;
            we_q    <= MemWrite;
            err_q   <= 1'b0;
            cnt     <= '0;
         end else if (state == REQ || state == RESP) begin
            cnt <= cnt + 8'd1;
         end
         if (set_err) err_q <= 1'b1;
         if (take_rd) ReadData <= rd_ext;
         else if (zero_rd) ReadData <= '0;
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   rbyte = mem_rdata[7:0];
         2'b01:   rbyte = mem_rdata[15:8];
         2'b10:   rbyte = mem_rdata[23:16];
         default: rbyte = mem_rdata[31:24];
      endcase
      rhalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  rd_ext = {{24{rbyte[7]}}, rbyte};
         3'b001:  rd_ext = {{16{rhalf[15]}}, rhalf};
         3'b100:  rd_ext = {24'd0, rbyte};
         3'b101:  rd_ext = {16'd0, rhalf};
         default: rd_ext = mem_rdata;
      endcase
   end

   always_comb begin
      mem_req  = (state == REQ);
      mem_we   = mem_req & we_q;
      mem_addr = {addr_q[31:2], 2'b00};
      mem_be   = '0;
      case (f3_q[1:0])
         2'b00: begin
            mem_wdata = {4{wdata_q[7:0]}};
            if (mem_req) mem_be = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            mem_wdata = {2{wdata_q[15:0]}};
            if (mem_req) mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            mem_wdata = wdata_q;
            if (mem_req) mem_be = 4'b1111;
         end
      endcase
      Stall = 1'b0;
      case (state)
         IDLE:      Stall = access;
         REQ, RESP: Stall = 1'b1;
         default:   Stall = 1'b0;
      endcase
      LsuErr = (state == DONE) & err_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scripted memory responder drives each
// access while a scoreboard queue holds the expected ReadData/LsuErr outcome.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] Addr, WriteData, ReadData;
   logic        Stall, LsuErr, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   sh, rc, qc;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .LsuErr(LsuErr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] rd, input logic err);
      exp_t e;
      e.rd  = rd;
      e.err = err;
      sb.push_back(e);
   endtask

   // Starts at posedge+1 in IDLE; holds the request until Stall drops.
   // gnt_at: REQ-cycle index of the grant; rv_at: 0 = with grant, n = n-th RESP cycle.
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int gnt_at, input int rv_at,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, output int stall_hi,
                             output int resp_cyc, output int req_cyc);
      int   cyc;
      bit   granted;
      bit   done;
      exp_t e;
      stall_hi = 0; resp_cyc = 0; req_cyc = 0; cyc = 0; granted = 0; done = 0;
      MemRead = rd; MemWrite = wr; funct3 = f3; Addr = addr; WriteData = wdata;
      while (!done && cyc < 100) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5;
         if (mem_req && req_cyc == gnt_at) begin
            mem_gnt = 1'b1;
            granted = 1;
            if (rv_at == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
         end else if (!mem_req && granted && Stall && resp_cyc + 1 == rv_at) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
         end
         #1;
         if (mem_req) begin
            req_cyc++;
            chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            chk({tag, " mem_we"}, mem_we, wr);
            if (wr) begin
               chk({tag, " mem_be"}, mem_be, exp_be);
               chk({tag, " mem_wdata"}, mem_wdata, exp_wd);
            end
         end else if (!Stall) begin
            done = 1;
            chk({tag, " idle_be"}, mem_be, 4'b0000);
            chk({tag, " idle_we"}, mem_we, 1'b0);
            if (sb.size() == 0) begin
               checks++; errors++;
               $error("FAIL %s scoreboard observed=empty expected=entry", tag);
            end else begin
               e = sb.pop_front();
               chk({tag, " LsuErr"}, LsuErr, e.err);
               chk({tag, " ReadData"}, ReadData, e.rd);
            end
         end
         if (Stall) begin
            stall_hi++;
            if (!mem_req && granted) resp_cyc++;
         end
         cyc++;
         if (!done) begin @(posedge clk); #1; end
      end
      if (!done) begin
         checks++; errors++;
         $error("FAIL %s completion observed=none expected=done within 100 cycles", tag);
         if (sb.size() != 0) void'(sb.pop_front());
      end
      MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(posedge clk); #1;
      chk({tag, " err_pulse_len"}, LsuErr, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
      Addr = '0; WriteData = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ReadData", ReadData, 32'h0);
      chk("rst LsuErr", LsuErr, 1'b0);
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst mem_we", mem_we, 1'b0);
      chk("rst mem_be", mem_be, 4'b0000);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst Stall idle", Stall, 1'b0);
      MemRead = 1'b1;
      #1;
      chk("rst Stall follows MemRead", Stall, 1'b1);
      MemRead = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      push(32'hDEADBEEF, 1'b0);
      run_access("lw", 1, 0, 3'b010, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0, 0, sh, rc, qc);
      chk("lw stall_cycles", sh, 3);
      chk("lw resp_cycles", rc, 1);

      push(32'hFFFFFF80, 1'b0);
      run_access("lb", 1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80112233, 0, 0, sh, rc, qc);
      chk("lb stall_cycles", sh, 2);
      push(32'h00000080, 1'b0);
      run_access("lbu", 1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80112233, 0, 0, sh, rc, qc);
      push(32'hFFFF8001, 1'b0);
      run_access("lh", 1, 0, 3'b001, 32'h102, 0, 1, 2, 32'h80017FFF, 0, 0, sh, rc, qc);
      push(32'h00007FFF, 1'b0);
      run_access("lhu", 1, 0, 3'b101, 32'h100, 0, 0, 1, 32'h80017FFF, 0, 0, sh, rc, qc);

      push(32'h00007FFF, 1'b0);
      run_access("sh", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 1, 0, 0, 4'b1100, 32'hABCDABCD, sh, rc, qc);
      chk("sh resp_cycles", rc, 0);
      chk("sh req_cycles", qc, 2);
      push(32'h00007FFF, 1'b0);
      run_access("sb", 0, 1, 3'b000, 32'h101, 32'h12345678, 0, 0, 0, 4'b0010, 32'h78787878, sh, rc, qc);
      push(32'h00007FFF, 1'b0);
      run_access("sw", 0, 1, 3'b010, 32'h104, 32'hCAFEBABE, 0, 0, 0, 4'b1111, 32'hCAFEBABE, sh, rc, qc);

      push(32'h00007FFF, 1'b1);
      run_access("bad_f3", 1, 0, 3'b011, 32'h100, 0, 0, 1, 32'h11111111, 0, 0, sh, rc, qc);
      chk("bad_f3 req_cycles", qc, 0);
      push(32'h00007FFF, 1'b1);
      run_access("rd_and_wr", 1, 1, 3'b010, 32'h100, 0, 0, 1, 32'h11111111, 0, 0, sh, rc, qc);
      push(32'h00007FFF, 1'b1);
      run_access("st_f3_1xx", 0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, sh, rc, qc);
      chk("st_f3_1xx req_cycles", qc, 0);

      push(32'h00000000, 1'b1);
      run_access("lw_mis", 1, 0, 3'b010, 32'h101, 0, 0, 1, 32'h22222222, 0, 0, sh, rc, qc);
      chk("lw_mis req_cycles", qc, 0);
      chk("lw_mis stall_cycles", sh, 1);

      push(32'h11223344, 1'b0);
      run_access("lw_slow", 1, 0, 3'b010, 32'h10C, 0, 2, 3, 32'h11223344, 0, 0, sh, rc, qc);
      chk("lw_slow stall_cycles", sh, 7);
      push(32'h11223344, 1'b1);
      run_access("sh_mis", 0, 1, 3'b001, 32'h201, 32'h1234, 0, 0, 0, 0, 0, sh, rc, qc);
      chk("sh_mis req_cycles", qc, 0);

      push(32'h00000000, 1'b1);
      run_access("tmo_resp", 1, 0, 3'b010, 32'h110, 0, 0, 1000, 0, 0, 0, sh, rc, qc);
      chk("tmo_resp reqresp_cycles", sh - 1, 16);
      chk("tmo_resp resp_cycles", rc, 15);

      push(32'h55667788, 1'b0);
      run_access("lw_b", 1, 0, 3'b010, 32'h114, 0, 0, 1, 32'h55667788, 0, 0, sh, rc, qc);
      push(32'h00000000, 1'b1);
      run_access("tmo_req", 1, 0, 3'b010, 32'h118, 0, 1000, 1000, 0, 0, 0, sh, rc, qc);
      chk("tmo_req req_cycles", qc, 16);

      push(32'h0BADF00D, 1'b0);
      run_access("lw_c", 1, 0, 3'b010, 32'h11C, 0, 0, 1, 32'h0BADF00D, 0, 0, sh, rc, qc);

      // Reset while waiting in RESP, then a stray rvalid after release.
      MemRead = 1'b1; funct3 = 3'b010; Addr = 32'h300;
      @(posedge clk); #1;
      chk("rstmid in_req", mem_req, 1'b1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(posedge clk); #1;
      chk("rstmid in_resp", {31'd0, mem_req} | {30'd0, Stall, 1'b0}, 32'h2);
      rst_n = 1'b0;
      #1;
      chk("rstmid mem_req", mem_req, 1'b0);
      chk("rstmid Stall read", Stall, 1'b1);
      chk("rstmid ReadData", ReadData, 32'h0);
      MemRead = 1'b0;
      #1;
      chk("rstmid Stall idle", Stall, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("late_rvalid ReadData", ReadData, 32'h0);
      chk("late_rvalid LsuErr", LsuErr, 1'b0);
      chk("late_rvalid mem_req", mem_req, 1'b0);

      chk("scoreboard drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
